vdp_palette_ram: RTL and testbench

- Programmable 16-entry colour palette for the nouveau-vdp99 video path.
- Maps the 4-bit TI99 colour code from the pixel pipeline to an RGB DAC value with parametrised bits per channel.
- The CPU can rewrite any entry through a V9938-style two-byte write sequence with an auto-incrementing index.
- Reset loads the stock TI99 palette, so the block is a drop-in for the fixed palette when never written.

---
 rtl/vdp_palette_ram.sv | 80 ++++++++
 tb/tb_vdp_palette_ram.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vdp_palette_ram.sv
// vdp_palette_ram: programmable 16-entry TI99 colour palette with V9938-style CPU writes
// Ports: clk, reset (async, active-high); idx_we/idx_data load the index pointer;
// dat_we/dat_data carry the two-byte entry write (first {-,R,-,B}, then {-,G});
// color/blank come from the pixel pipeline; red/grn/blu are registered DAC values
// (top DW bits of each 3-bit field); phase shows which byte is expected next.
module vdp_palette_ram #(
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          idx_we,
    input  logic [3:0]    idx_data,
    input  logic          dat_we,
    input  logic [7:0]    dat_data,
    input  logic [3:0]    color,
    input  logic          blank,
    output logic [DW-1:0] red,
    output logic [DW-1:0] grn,
    output logic [DW-1:0] blu,
    output logic          phase
);
    typedef enum logic {FIRST, SECOND} state_t;
    // stock TI99 palette, 2 bits per channel as {R,G,B}
    localparam logic [5:0] TI [16] = '{
        6'b00_00_00, 6'b00_00_00, 6'b00_10_00, 6'b00_11_00,
        6'b00_00_01, 6'b00_00_11, 6'b01_00_00, 6'b00_11_11,
        6'b10_00_00, 6'b11_00_00, 6'b01_01_00, 6'b11_11_00,
        6'b00_01_00, 6'b11_00_11, 6'b01_01_01, 6'b11_11_11
    };
    state_t      state, state_nx;
    logic        commit;
    logic [3:0]  idx;
    logic [2:0]  r_hold, b_hold;
    logic [8:0]  pal [16];
    logic        unused_bits;
    assign unused_bits = ^{dat_data[7], dat_data[3]};
    assign phase = (state == SECOND);
    function automatic logic [2:0] expand(input logic [1:0] v);
        return {v, v[1]};
    endfunction
    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        if (idx_we)
            state_nx = FIRST;
        else if (dat_we) begin
            state_nx = (state == FIRST) ? SECOND : FIRST;
            commit   = (state == SECOND);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FIRST;
            idx    <= '0;
            r_hold <= '0;
            b_hold <= '0;
            red    <= '0;
            grn    <= '0;
            blu    <= '0;
            for (int i = 0; i < 16; i++)
                pal[i] <= {expand(TI[i][5:4]), expand(TI[i][3:2]), expand(TI[i][1:0])};
        end else begin
            state <= state_nx;
            // nonblocking read of pal gives read-before-write on a same-cycle commit
            red <= blank ? '0 : pal[color][8 -: DW];
            grn <= blank ? '0 : pal[color][5 -: DW];
            blu <= blank ? '0 : pal[color][2 -: DW];
            if (idx_we)
                idx <= idx_data;
            else if (commit) begin
                pal[idx] <= {r_hold, dat_data[2:0], b_hold};
                idx      <= idx + 4'd1;
            end
            if (!idx_we && dat_we && state == FIRST) begin
                r_hold <= dat_data[6:4];
                b_hold <= dat_data[2:0];
            end
        end
    end
endmodule

// File: tb/tb_vdp_palette_ram.sv
// tb_vdp_palette_ram: directed self-checking bench for vdp_palette_ram at DW=2 and DW=3
module tb_vdp_palette_ram;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic idx_we = 1'b0;
    logic [3:0] idx_data = '0;
    logic dat_we = 1'b0;
    logic [7:0] dat_data = '0;
    logic [3:0] color = '0;
    logic blank = 1'b0;
    logic [1:0] red, grn, blu;
    logic [2:0] red3, grn3, blu3;
    logic phase, phase3;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] c;
        logic       bl;
        int         r, g, b;
    } vec_t;
    vec_t v [17];

    always #5 clk = ~clk;

    vdp_palette_ram #(.DW(2)) dut (
        .clk(clk), .reset(reset), .idx_we(idx_we), .idx_data(idx_data),
        .dat_we(dat_we), .dat_data(dat_data), .color(color), .blank(blank),
        .red(red), .grn(grn), .blu(blu), .phase(phase)
    );
    vdp_palette_ram #(.DW(3)) dut3 (
        .clk(clk), .reset(reset), .idx_we(idx_we), .idx_data(idx_data),
        .dat_we(dat_we), .dat_data(dat_data), .color(color), .blank(blank),
        .red(red3), .grn(grn3), .blu(blu3), .phase(phase3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rgb2(input string name, input int er, input int eg, input int eb);
        total++;
        if (int'(red) != er || int'(grn) != eg || int'(blu) != eb) begin
            bad++;
            $display("FAIL %s: got %0d,%0d,%0d expected %0d,%0d,%0d", name, red, grn, blu, er, eg, eb);
        end
    endtask

    task automatic rgb3(input string name, input int er, input int eg, input int eb);
        total++;
        if (int'(red3) != er || int'(grn3) != eg || int'(blu3) != eb) begin
            bad++;
            $display("FAIL %s: got %0d,%0d,%0d expected %0d,%0d,%0d", name, red3, grn3, blu3, er, eg, eb);
        end
    endtask

    task automatic ix(input logic [3:0] i);
        idx_we = 1'b1;
        idx_data = i;
        tick();
        idx_we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        dat_we = 1'b1;
        dat_data = b;
        tick();
        dat_we = 1'b0;
    endtask

    task automatic look(input logic [3:0] c);
        color = c;
        tick();
    endtask

    initial begin
        v[0]  = '{4'h0, 1'b0, 0, 0, 0};
        v[1]  = '{4'h1, 1'b0, 0, 0, 0};
        v[2]  = '{4'h2, 1'b0, 0, 2, 0};
        v[3]  = '{4'h3, 1'b0, 0, 3, 0};
        v[4]  = '{4'h4, 1'b0, 0, 0, 1};
        v[5]  = '{4'h5, 1'b0, 0, 0, 3};
        v[6]  = '{4'h6, 1'b0, 1, 0, 0};
        v[7]  = '{4'h7, 1'b0, 0, 3, 3};
        v[8]  = '{4'h8, 1'b0, 2, 0, 0};
        v[9]  = '{4'h9, 1'b0, 3, 0, 0};
        v[10] = '{4'ha, 1'b0, 1, 1, 0};
        v[11] = '{4'hb, 1'b0, 3, 3, 0};
        v[12] = '{4'hc, 1'b0, 0, 1, 0};
        v[13] = '{4'hd, 1'b0, 3, 0, 3};
        v[14] = '{4'he, 1'b0, 1, 1, 1};
        v[15] = '{4'hf, 1'b0, 3, 3, 3};
        v[16] = '{4'hf, 1'b1, 0, 0, 0};

        #1 reset = 1'b1;
        #2;
        rgb2("reset_out", 0, 0, 0);
        chk("reset_phase", int'(phase), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // default table sweep, one clock latency, plus blanking
        for (int i = 0; i < 17; i++) begin
            color = v[i].c;
            blank = v[i].bl;
            tick();
            rgb2($sformatf("default_c%0h_bl%0d", v[i].c, v[i].bl), v[i].r, v[i].g, v[i].b);
        end
        blank = 1'b0;
        look(4'h7);
        rgb3("default3_c7", 0, 7, 7);
        look(4'he);
        rgb3("default3_ce", 2, 2, 2);

        // basic two-byte write to entry 4, pointer then at 5
        ix(4'h4);
        chk("idx_phase", int'(phase), 0);
        wr(8'h70);
        chk("byte1_phase", int'(phase), 1);
        wr(8'h05);
        chk("byte2_phase", int'(phase), 0);
        look(4'h4);
        rgb2("entry4", 3, 2, 0);
        rgb3("entry4_3", 7, 5, 0);
        wr(8'h77);
        wr(8'h07);
        look(4'h5);
        rgb2("entry5_autoinc", 3, 3, 3);

        // index wrap f -> 0
        ix(4'hf);
        wr(8'h11);
        wr(8'h01);
        wr(8'h22);
        wr(8'h02);
        look(4'hf);
        rgb3("wrap_f3", 1, 1, 1);
        rgb2("wrap_f2", 0, 0, 0);
        look(4'h0);
        rgb3("wrap_03", 2, 2, 2);
        rgb2("wrap_02", 1, 1, 1);

        // idx_we discards pending first byte
        wr(8'h77);
        ix(4'h2);
        chk("discard_phase0", int'(phase), 0);
        wr(8'h00);
        chk("discard_phase1", int'(phase), 1);
        look(4'h2);
        rgb2("discard_entry2", 0, 2, 0);

        // idx_we wins over simultaneous dat_we
        idx_we = 1'b1;
        idx_data = 4'h6;
        dat_we = 1'b1;
        dat_data = 8'h55;
        tick();
        idx_we = 1'b0;
        dat_we = 1'b0;
        chk("idx_wins_phase", int'(phase), 0);
        wr(8'h77);
        wr(8'h07);
        look(4'h6);
        rgb2("idx_wins_entry6", 3, 3, 3);

        // read-before-write collision on entry 9
        ix(4'h9);
        wr(8'h77);
        color = 4'h9;
        wr(8'h07);
        rgb2("collide_old", 3, 0, 0);
        tick();
        rgb2("collide_new", 3, 3, 3);

        // async reset mid-sequence restores defaults
        ix(4'h3);
        wr(8'h77);
        wr(8'h07);
        look(4'h3);
        rgb2("entry3_new", 3, 3, 3);
        ix(4'h3);
        wr(8'h11);
        chk("pre_reset_phase", int'(phase), 1);
        reset = 1'b1;
        #1;
        rgb2("async_reset_out", 0, 0, 0);
        chk("async_reset_phase", int'(phase), 0);
        #1 reset = 1'b0;
        color = 4'h3;
        blank = 1'b1;
        tick();
        rgb2("blanked", 0, 0, 0);
        blank = 1'b0;
        tick();
        rgb2("entry3_restored", 0, 3, 0);
        wr(8'h77);
        wr(8'h07);
        look(4'h0);
        rgb2("ptr_reset_entry0", 3, 3, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
